adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
- Sequential checker directly downstream of the five-way 32-bit adder comparison block.
- Captures an operand pair together with the CRA, CLA, CSA, CSKA and KSA sums over a valid/ready handshake.
- Computes the golden sum, flags each adder that disagrees, and keeps saturating vector and error counters plus a sticky first-failure record.
- Used in the FPGA/sim harness to qualify all adder architectures against one stimulus stream.

Parameters:
- WIDTH, 32, operand and sum width; golden sum is (i_a + i_b) mod 2^WIDTH, carry-out discarded.
- CNT_W, 16, width of the vector and error counters.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream has a vector on i_a/i_b/i_sum_*.
- o_ready  output  1  checker can accept a vector (high only in IDLE).
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sum_cra  input  WIDTH  ripple-carry result.
- i_sum_cla  input  WIDTH  look-ahead result.
- i_sum_csa  input  WIDTH  carry-select result.
- i_sum_cska  input  WIDTH  carry-skip result.
- i_sum_ksa  input  WIDTH  Kogge-Stone result.
- i_clear  input  1  synchronous clear of counters and sticky state.
- o_result_valid  output  1  one-cycle pulse: o_mismatch is valid for the last accepted vector.
- o_mismatch  output  5  per-vector mismatch; bit0 CRA, bit1 CLA, bit2 CSA, bit3 CSKA, bit4 KSA.
- o_err_mask  output  5  sticky OR of all o_mismatch values since reset/clear.
- o_vec_cnt  output  CNT_W  vectors checked, saturating.
- o_err_cnt  output  CNT_W  vectors with any mismatch, saturating.
- o_first_fail_valid  output  1  a failing vector has been recorded.
- o_first_fail_a  output  WIDTH  operand A of the first failing vector.
- o_first_fail_b  output  WIDTH  operand B of the first failing vector.

Behaviour:
- Reset (i_rst_n low, async): FSM enters IDLE and every output is 0 except o_ready, which is 1; all capture registers are cleared.
- FSM states:
  - IDLE: o_ready=1. If i_valid is high at a clock edge, register i_a, i_b and the five sums, then go to CHECK. If i_valid is low, stay.
  - CHECK: golden = a_q + b_q truncated to WIDTH. Register mismatch[k] = (sum_k_q != golden). Go to UPDATE.
  - UPDATE: o_result_valid=1 for this cycle only. o_mismatch is driven and holds until the next UPDATE. Counters and sticky state update. Return to IDLE.
- Timing: a vector accepted at edge N gives o_result_valid high during cycle N+2. o_ready is low for 2 cycles, so throughput is 1 vector per 3 cycles. Inputs are don't-care outside the accept edge.
- Updates in UPDATE:
  - o_vec_cnt += 1, saturating at 2^CNT_W-1.
  - If mismatch != 0: o_err_cnt += 1 (saturating) and o_err_mask |= mismatch.
  - If mismatch != 0 and o_first_fail_valid == 0: capture a_q/b_q into o_first_fail_a/o_first_fail_b and set o_first_fail_valid. Later failures do not overwrite this record.
- i_clear (synchronous, any state): next edge zeroes o_vec_cnt, o_err_cnt, o_err_mask, o_first_fail_* and o_mismatch.
  - Clear has priority over a coincident UPDATE: that vector's counter/sticky update is dropped, but o_result_valid still pulses, with o_mismatch showing its computed value.
  - i_clear does not change FSM state or o_ready.
- Arithmetic wraps at WIDTH bits; 0xFFFFFFFF + 1 has golden 0x00000000.
- Async reset mid-CHECK/UPDATE: vector abandoned, no o_result_valid pulse, checker is back in IDLE with o_ready=1 after reset release.

Test Plan:
- Reset check -> o_ready=1, all counters/flags 0; a=3, b=5, all sums 8 -> o_result_valid exactly 2 cycles after accept, o_mismatch=0, o_vec_cnt=1, o_err_cnt=0.
- Wrap case: a=0xFFFFFFFF, b=1, all sums 0 -> no mismatch; same vector with i_sum_csa=0x00000001 -> o_mismatch=5'b00100, o_err_mask=5'b00100, first_fail a=0xFFFFFFFF, b=1.
- Two failing vectors back-to-back (KSA wrong, then CRA wrong) -> o_err_cnt=2, o_err_mask=5'b10001, first_fail holds the first vector; i_valid held high throughout -> o_ready low 2 of every 3 cycles, no vector lost or duplicated.
- Saturation with CNT_W=4: 20 vectors, all sums wrong -> o_vec_cnt=15, o_err_cnt=15.
- i_clear asserted in the UPDATE cycle of a failing vector -> pulse seen with nonzero o_mismatch; next cycle counters=0, o_err_mask=0, o_first_fail_valid=0.
- i_rst_n dropped in CHECK -> no o_result_valid pulse, outputs at reset values immediately, o_ready=1 after release.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker
// Qualifies five 32-bit adder architectures against a golden sum. Each
// accepted vector walks IDLE -> CHECK -> UPDATE. The bench sees a per-adder
// mismatch pulse, saturating vector/error counters, a sticky error mask and
// the operands of the first failing vector.
module adder_result_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum_cra,
  input  logic [WIDTH-1:0] i_sum_cla,
  input  logic [WIDTH-1:0] i_sum_csa,
  input  logic [WIDTH-1:0] i_sum_cska,
  input  logic [WIDTH-1:0] i_sum_ksa,
  input  logic             i_clear,
  output logic             o_result_valid,
  output logic [4:0]       o_mismatch,
  output logic [4:0]       o_err_mask,
  output logic [CNT_W-1:0] o_vec_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_first_fail_valid,
  output logic [WIDTH-1:0] o_first_fail_a,
  output logic [WIDTH-1:0] o_first_fail_b
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  // Index order matches o_mismatch: 0 CRA, 1 CLA, 2 CSA, 3 CSKA, 4 KSA.
  logic [4:0][WIDTH-1:0] sum_q;
  logic [WIDTH-1:0]      golden;
  logic [4:0]            mismatch_c;

  // Golden sum wraps at WIDTH bits; compare every captured adder result to it.
  always_comb begin
    golden     = a_q + b_q;
    mismatch_c = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      mismatch_c[k] = (sum_q[k] != golden);
    end
  end

  // Handshake FSM, per-vector result register and the statistics it feeds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      o_ready            <= 1'b1;
      a_q                <= '0;
      b_q                <= '0;
      sum_q              <= '0;
      o_result_valid     <= 1'b0;
      o_mismatch         <= '0;
      o_err_mask         <= '0;
      o_vec_cnt          <= '0;
      o_err_cnt          <= '0;
      o_first_fail_valid <= 1'b0;
      o_first_fail_a     <= '0;
      o_first_fail_b     <= '0;
    end else begin
      o_result_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_b;
            sum_q   <= {i_sum_ksa, i_sum_cska, i_sum_csa, i_sum_cla, i_sum_cra};
            o_ready <= 1'b0;
            state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          o_mismatch     <= mismatch_c;
          o_result_valid <= 1'b1;
          state          <= ST_UPDATE;
        end

        ST_UPDATE: begin
          if (!i_clear) begin
            if (o_vec_cnt != '1) begin
              o_vec_cnt <= o_vec_cnt + 1'b1;
            end
            if (o_mismatch != '0) begin
              if (o_err_cnt != '1) begin
                o_err_cnt <= o_err_cnt + 1'b1;
              end
              o_err_mask <= o_err_mask | o_mismatch;
              if (!o_first_fail_valid) begin
                o_first_fail_valid <= 1'b1;
                o_first_fail_a     <= a_q;
                o_first_fail_b     <= b_q;
              end
            end
          end
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end

        default: begin
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase

      // Placed after the case so clear overrides any update scheduled above.
      // The FSM, o_ready and o_result_valid are deliberately left untouched.
      if (i_clear) begin
        o_mismatch         <= '0;
        o_err_mask         <= '0;
        o_vec_cnt          <= '0;
        o_err_cnt          <= '0;
        o_first_fail_valid <= 1'b0;
        o_first_fail_a     <= '0;
        o_first_fail_b     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Self-checking bench for adder_result_checker: a vector table plus
// hand-written multi-cycle sequences, with a mismatch scoreboard.
module tb_adder_result_checker;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cra;
    logic [31:0] cla;
    logic [31:0] csa;
    logic [31:0] cska;
    logic [31:0] ksa;
    logic [4:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] s_cra = '0, s_cla = '0, s_csa = '0, s_cska = '0, s_ksa = '0;

  logic        ready, rv, ffv;
  logic [4:0]  mism, mask;
  logic [15:0] vcnt, ecnt;
  logic [31:0] ffa, ffb;

  logic        sm_ready, sm_rv, sm_ffv;
  logic [4:0]  sm_mism, sm_mask;
  logic [3:0]  sm_vcnt, sm_ecnt;
  logic [31:0] sm_ffa, sm_ffb;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [4:0] sb_q[$];
  logic [4:0] mon_exp;

  int unsigned m_vec, m_err;
  logic [4:0]  m_mask;
  logic        m_ffv;
  logic [31:0] m_ffa, m_ffb;

  vec_t tbl[6];

  adder_result_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_a(a), .i_b(b), .i_sum_cra(s_cra), .i_sum_cla(s_cla), .i_sum_csa(s_csa),
    .i_sum_cska(s_cska), .i_sum_ksa(s_ksa), .i_clear(clear),
    .o_result_valid(rv), .o_mismatch(mism), .o_err_mask(mask),
    .o_vec_cnt(vcnt), .o_err_cnt(ecnt), .o_first_fail_valid(ffv),
    .o_first_fail_a(ffa), .o_first_fail_b(ffb)
  );

  adder_result_checker #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(sm_ready),
    .i_a(a), .i_b(b), .i_sum_cra(s_cra), .i_sum_cla(s_cla), .i_sum_csa(s_csa),
    .i_sum_cska(s_cska), .i_sum_ksa(s_ksa), .i_clear(clear),
    .o_result_valid(sm_rv), .o_mismatch(sm_mism), .o_err_mask(sm_mask),
    .o_vec_cnt(sm_vcnt), .o_err_cnt(sm_ecnt), .o_first_fail_valid(sm_ffv),
    .o_first_fail_a(sm_ffa), .o_first_fail_b(sm_ffb)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && rv) begin
      pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("mismatch", {59'd0, mism}, {59'd0, mon_exp});
      end
    end
  end

  task automatic model_reset();
    m_vec = 0; m_err = 0; m_mask = '0; m_ffv = 1'b0; m_ffa = '0; m_ffb = '0;
  endtask

  task automatic model_update(input vec_t v);
    if (m_vec < 65535) m_vec++;
    if (v.exp != 5'd0) begin
      if (m_err < 65535) m_err++;
      m_mask = m_mask | v.exp;
      if (!m_ffv) begin
        m_ffv = 1'b1; m_ffa = v.a; m_ffb = v.b;
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_vec_cnt"}, vcnt, m_vec);
    chk({tag, "_err_cnt"}, ecnt, m_err);
    chk({tag, "_err_mask"}, mask, m_mask);
    chk({tag, "_ff_valid"}, ffv, m_ffv);
    chk({tag, "_ff_a"}, ffa, m_ffa);
    chk({tag, "_ff_b"}, ffb, m_ffb);
  endtask

  task automatic drive_vec(input vec_t v);
    a = v.a; b = v.b;
    s_cra = v.cra; s_cla = v.cla; s_csa = v.csa; s_cska = v.cska; s_ksa = v.ksa;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input vec_t v, input string tag);
    wait_ready();
    drive_vec(v);
    valid = 1'b1;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rv_early"}, rv, 0);
    chk({tag, "_ready_busy"}, ready, 0);
    @(negedge clk);
    chk({tag, "_rv_pulse"}, rv, 1);
    @(negedge clk);
    chk({tag, "_rv_after"}, rv, 0);
    chk({tag, "_ready_back"}, ready, 1);
    model_update(v);
    check_state(tag);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_state("clear");
    chk("clear_ready", ready, 1);
    chk("clear_sat_vec", sm_vcnt, 0);
  endtask

  initial begin
    vec_t v0, v1, vf;
    int p0;

    tbl[0] = '{32'd3, 32'd5, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 5'b00000};
    tbl[1] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'b00000};
    tbl[2] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 5'b00100};
    tbl[3] = '{32'h12345678, 32'h11111111, 32'h23456789, 32'h23456788,
               32'h23456789, 32'hA3456789, 32'h23456789, 5'b01010};
    tbl[4] = '{32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'b00000};
    tbl[5] = '{32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
               32'hDEADBEEF, 32'hDEADBEEF, 5'b11111};

    model_reset();

    // Reset values, both while held and after release.
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rv", rv, 0);
    chk("rst_mismatch", mism, 0);
    check_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", ready, 1);
    check_state("rel");

    // Table of vectors.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i], $sformatf("tbl%0d", i));
    end

    // Back-to-back failures with i_valid held high.
    do_clear();
    v0 = '{32'h000000FF, 32'd1, 32'h100, 32'h100, 32'h100, 32'h100, 32'h101, 5'b10000};
    v1 = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 5'b00001};
    wait_ready();
    drive_vec(v0);
    valid = 1'b1;
    sb_q.push_back(v0.exp);
    p0 = pulses;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", k), ready, (k % 3 == 0));
      if (k == 3) begin
        drive_vec(v1);
        sb_q.push_back(v1.exp);
      end
      if (k == 6) valid = 1'b0;
    end
    model_update(v0);
    model_update(v1);
    check_state("b2b");
    chk("b2b_pulses", pulses - p0, 2);
    repeat (4) @(negedge clk);
    chk("b2b_no_extra", pulses - p0, 2);

    // Saturation on the 4-bit counter instance.
    do_clear();
    vf = '{32'd100, 32'd200, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 5'b11111};
    for (int i = 0; i < 20; i++) begin
      send(vf, "sat");
    end
    chk("sat_small_vec", sm_vcnt, 15);
    chk("sat_small_err", sm_ecnt, 15);
    chk("sat_small_mask", sm_mask, 5'b11111);

    // Async reset while in CHECK abandons the vector.
    wait_ready();
    drive_vec(vf);
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("rstchk_busy", ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstchk_ready", ready, 1);
    chk("rstchk_rv", rv, 0);
    chk("rstchk_mismatch", mism, 0);
    model_reset();
    check_state("rstchk");
    p0 = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstchk_no_pulse", pulses - p0, 0);
    chk("rstchk_ready_after", ready, 1);

    // Clear coincident with UPDATE of a failing vector.
    send(tbl[2], "preclr");
    v0 = '{32'd10, 32'd20, 32'd30, 32'd30, 32'd30, 32'd31, 32'd30, 5'b01000};
    wait_ready();
    drive_vec(v0);
    valid = 1'b1;
    sb_q.push_back(v0.exp);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clrupd_pulse", rv, 1);
    chk("clrupd_mism", mism, 5'b01000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_state("clrupd");
    chk("clrupd_mism_zero", mism, 0);
    chk("clrupd_ready", ready, 1);
    chk("clrupd_rv_low", rv, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
